// File: rtl/weight_update_pkg.sv
// Shared definitions for the weight-update stage: FSM states and accumulator sizing.
package weight_update_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Extra integer bits carried by the gradient accumulator above the data word.
  localparam int unsigned ACC_GUARD = 8;

endpackage

// File: rtl/weight_update_wu_mac.sv
// Signed fixed-point multiply-accumulate with a saturated narrow output.
// o_sum already includes the current product (when i_en), so a caller can use
// the final sum in the same cycle it clears the accumulator.
module wu_mac #(
  parameter int unsigned AW   = 32,
  parameter int unsigned BW   = 32,
  parameter int unsigned ACCW = 40,
  parameter int unsigned FRAC = 24,
  parameter int unsigned OW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [AW-1:0]   i_a,
  input  logic [BW-1:0]   i_b,
  output logic [ACCW-1:0] o_sum,
  output logic [OW-1:0]   o_sat
);

  localparam int unsigned PW = AW + BW;

  logic signed [PW-1:0]   w_prod;
  logic signed [ACCW-1:0] w_term;
  logic signed [ACCW-1:0] w_sum;
  logic signed [ACCW-1:0] r_acc;

  // Full-precision product, floor-shifted to Q(FRAC), added to the running sum.
  always_comb begin
    w_prod = PW'($signed(i_a)) * PW'($signed(i_b));
    w_term = ACCW'(w_prod >>> FRAC);
    w_sum  = r_acc + (i_en ? w_term : '0);
    o_sum  = w_sum;
    if ((w_sum[ACCW-1:OW-1] == '0) || (w_sum[ACCW-1:OW-1] == '1))
      o_sat = w_sum[OW-1:0];
    else if (w_sum[ACCW-1])
      o_sat = {1'b1, {(OW-1){1'b0}}};
    else
      o_sat = {1'b0, {(OW-1){1'b1}}};
  end

  // Accumulator register; clear wins over accumulate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= w_sum;
  end

endmodule

// File: rtl/weight_update.sv
// SGD weight/bias update for one gate: W -= lr * sum_t(dgate[t][r] * x[t][c]).
module weight_update
  import weight_update_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned FRAC     = 24,
  parameter int unsigned N_ROW    = 8,
  parameter int unsigned N_COL    = 53,
  parameter int unsigned TIMESTEP = 7,
  parameter int unsigned D_ADDR   = 6,
  parameter int unsigned X_ADDR   = 9,
  parameter int unsigned W_ADDR   = 9,
  parameter int unsigned B_ADDR   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  lr,
  output logic              busy,
  output logic              done,
  output logic [D_ADDR-1:0] d_rd_addr,
  input  logic [WIDTH-1:0]  d_rd_data,
  output logic [X_ADDR-1:0] x_rd_addr,
  input  logic [WIDTH-1:0]  x_rd_data,
  output logic [W_ADDR-1:0] w_rd_addr,
  input  logic [WIDTH-1:0]  w_rd_data,
  output logic              w_wr,
  output logic [W_ADDR-1:0] w_wr_addr,
  output logic [WIDTH-1:0]  w_wr_data,
  output logic [B_ADDR-1:0] b_rd_addr,
  input  logic [WIDTH-1:0]  b_rd_data,
  output logic              b_wr,
  output logic [B_ADDR-1:0] b_wr_addr,
  output logic [WIDTH-1:0]  b_wr_data
);

  localparam int unsigned ACCW = WIDTH + ACC_GUARD;
  localparam int unsigned TW   = $clog2(TIMESTEP + 1);
  localparam int unsigned RW   = $clog2(N_ROW + 1);
  localparam int unsigned CW   = $clog2(N_COL + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

  state_t           r_state, w_nxt;
  logic [TW-1:0]    r_t;
  logic [RW-1:0]    r_r;
  logic [CW-1:0]    r_c;
  logic [WIDTH-1:0] r_lr, r_wold;

  logic             w_bias, w_last_t, w_last_el, w_clr, w_en;
  logic [WIDTH-1:0] w_x, w_old, w_upd, w_new;
  logic [WIDTH:0]   w_diff;
  logic [ACCW-1:0]  w_grad_sum;
  logic [ACCW+WIDTH-1:0] w_unused_scale_sum;

  assign w_bias    = (r_c == CW'(N_COL));
  assign w_last_t  = (r_t == TW'(TIMESTEP - 1));
  assign w_last_el = w_bias && (r_r == RW'(N_ROW - 1));
  assign w_x       = w_bias ? ONE : x_rd_data;

  // With a single timestep the old value arrives in WB itself, so bypass the register.
  assign w_old = (TIMESTEP == 1) ? (w_bias ? b_rd_data : w_rd_data) : r_wold;

  wu_mac #(.AW(WIDTH), .BW(WIDTH), .ACCW(ACCW), .FRAC(FRAC), .OW(WIDTH)) u_grad (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_en(w_en),
    .i_a(d_rd_data), .i_b(w_x), .o_sum(w_grad_sum), .o_sat()
  );

  // Same MAC held permanently cleared: a pure saturated lr * gradient scaler.
  wu_mac #(.AW(WIDTH), .BW(ACCW), .ACCW(ACCW + WIDTH), .FRAC(FRAC), .OW(WIDTH)) u_scale (
    .clk(clk), .rst(rst), .i_clr(1'b1), .i_en(1'b1),
    .i_a(r_lr), .i_b(w_grad_sum), .o_sum(w_unused_scale_sum), .o_sat(w_upd)
  );

  // Saturating subtract of the scaled gradient from the stored value.
  always_comb begin
    w_diff = {w_old[WIDTH-1], w_old} - {w_upd[WIDTH-1], w_upd};
    if (w_diff[WIDTH] != w_diff[WIDTH-1])
      w_new = w_diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      w_new = w_diff[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  // Next-state decode, memory addressing and write strobes.
  always_comb begin
    w_nxt     = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    w_clr     = 1'b0;
    w_en      = 1'b0;
    d_rd_addr = '0;
    x_rd_addr = '0;
    w_rd_addr = '0;
    b_rd_addr = '0;
    w_wr      = 1'b0;
    w_wr_addr = '0;
    w_wr_data = '0;
    b_wr      = 1'b0;
    b_wr_addr = '0;
    b_wr_data = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clr = 1'b1;
          w_nxt = S_MAC;
        end
      end
      S_MAC: begin
        busy      = 1'b1;
        w_en      = (r_t != '0);
        d_rd_addr = D_ADDR'(32'(r_t) * N_ROW + 32'(r_r));
        x_rd_addr = X_ADDR'(32'(r_t) * N_COL + 32'(r_c));
        if (r_t == '0) begin
          if (w_bias) b_rd_addr = B_ADDR'(r_r);
          else        w_rd_addr = W_ADDR'(32'(r_r) * N_COL + 32'(r_c));
        end
        if (w_last_t) w_nxt = S_WB;
      end
      S_WB: begin
        busy  = 1'b1;
        w_en  = 1'b1;
        w_clr = 1'b1;
        if (w_bias) begin
          b_wr      = 1'b1;
          b_wr_addr = B_ADDR'(r_r);
          b_wr_data = w_new;
        end else begin
          w_wr      = 1'b1;
          w_wr_addr = W_ADDR'(32'(r_r) * N_COL + 32'(r_c));
          w_wr_data = w_new;
        end
        w_nxt = w_last_el ? S_DONE : S_MAC;
      end
      S_DONE: begin
        done  = 1'b1;
        w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Counters, latched learning rate and captured old weight/bias.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_t    <= '0;
      r_r    <= '0;
      r_c    <= '0;
      r_lr   <= '0;
      r_wold <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_lr <= lr;
            r_t  <= '0;
            r_r  <= '0;
            r_c  <= '0;
          end
        end
        S_MAC: begin
          r_t <= w_last_t ? '0 : r_t + TW'(1);
          if (r_t == TW'(1)) r_wold <= w_bias ? b_rd_data : w_rd_data;
        end
        S_WB: begin
          if (w_bias) begin
            r_c <= '0;
            r_r <= w_last_el ? '0 : r_r + RW'(1);
          end else begin
            r_c <= r_c + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_update.sv
// Bench for weight_update on a 2x2 array, 2 timesteps, with simple memory models.
module tb_weight_update;

  localparam int NR = 2;
  localparam int NC = 2;
  localparam int TS = 2;
  localparam int NEL = NR * (NC + 1);
  localparam int NBUSY = NEL * (TS + 1);
  localparam logic [31:0] ONE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] lr;
  logic        busy, done, w_wr, b_wr;
  logic [5:0]  d_rd_addr;
  logic [8:0]  x_rd_addr, w_rd_addr, w_wr_addr;
  logic [3:0]  b_rd_addr, b_wr_addr;
  logic [31:0] d_rd_data, x_rd_data, w_rd_data, b_rd_data, w_wr_data, b_wr_data;

  logic [31:0] dmem [64];
  logic [31:0] xmem [512];
  logic [31:0] wmem [512];
  logic [31:0] bmem [16];

  typedef struct { string name; logic [31:0] d, x, lr, w, b, ew, eb; } vec_t;
  typedef struct { bit is_b; int unsigned addr; logic [31:0] data; } sb_t;

  sb_t  sbq [$];
  vec_t vecs [6];
  int   n_cmp = 0;
  int   n_err = 0;

  weight_update #(.N_ROW(NR), .N_COL(NC), .TIMESTEP(TS)) dut (
    .clk(clk), .rst(rst), .start(start), .lr(lr), .busy(busy), .done(done),
    .d_rd_addr(d_rd_addr), .d_rd_data(d_rd_data),
    .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
    .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .w_wr(w_wr), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .b_wr(b_wr), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency read ports.
  always @(posedge clk) begin
    d_rd_data <= dmem[d_rd_addr];
    x_rd_data <= xmem[x_rd_addr];
    w_rd_data <= wmem[w_rd_addr];
    b_rd_data <= bmem[b_rd_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every write must match the next scoreboard entry.
  always @(negedge clk) begin
    sb_t e;
    if (rst && (w_wr || b_wr)) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: w_wr=%0d b_wr=%0d with nothing expected", w_wr, b_wr);
      end else begin
        e = sbq.pop_front();
        chk("wr_flags", 64'({w_wr, b_wr}), e.is_b ? 64'd1 : 64'd2);
        chk("wr_addr", e.is_b ? 64'(b_wr_addr) : 64'(w_wr_addr), 64'(e.addr));
        chk("wr_data", e.is_b ? 64'(b_wr_data) : 64'(w_wr_data), 64'(e.data));
      end
    end
  end

  function automatic logic [31:0] sat32(input longint v);
    if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  task automatic fill_uniform(input vec_t v);
    for (int i = 0; i < 64; i++)  dmem[i] = v.d;
    for (int i = 0; i < 512; i++) begin xmem[i] = v.x; wmem[i] = v.w; end
    for (int i = 0; i < 16; i++)  bmem[i] = v.b;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++)  dmem[i] = $urandom_range(32'h0400_0000) - 32'h0200_0000;
    for (int i = 0; i < 512; i++) begin
      xmem[i] = $urandom_range(32'h0400_0000) - 32'h0200_0000;
      wmem[i] = $urandom();
    end
    for (int i = 0; i < 16; i++)  bmem[i] = $urandom();
  endtask

  task automatic push_table(input vec_t v);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c <= NC; c++)
        sbq.push_back('{is_b: (c == NC), addr: (c == NC) ? r : r * NC + c,
                        data: (c == NC) ? v.eb : v.ew});
  endtask

  // Reference model from the pre-pass memory contents.
  task automatic push_model(input logic [31:0] plr);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c <= NC; c++) begin
        longint acc, p, upd, nw;
        logic [31:0] xv, wold;
        acc = 0;
        for (int t = 0; t < TS; t++) begin
          xv  = (c == NC) ? ONE : xmem[t * NC + c];
          p   = longint'($signed(dmem[t * NR + r])) * longint'($signed(xv));
          acc = acc + (p >>> 24);
        end
        wold = (c == NC) ? bmem[r] : wmem[r * NC + c];
        upd  = longint'($signed(sat32((longint'($signed(plr)) * acc) >>> 24)));
        nw   = longint'($signed(wold)) - upd;
        sbq.push_back('{is_b: (c == NC), addr: (c == NC) ? r : r * NC + c, data: sat32(nw)});
      end
  endtask

  task automatic run_pass(input logic [31:0] plr, input int mid_at, input logic [31:0] mid_lr,
                          output int busy_n, output int done_n, output int both_n);
    int cyc, tail;
    bit seen;
    busy_n = 0; done_n = 0; both_n = 0; cyc = 0; tail = 0; seen = 0;
    @(negedge clk);
    start = 1'b1;
    lr    = plr;
    @(negedge clk);
    start = 1'b0;
    lr    = ~plr;
    while (cyc < 400 && !(seen && tail >= 4)) begin
      if (busy && done) both_n++;
      if (busy) busy_n++;
      if (done) begin done_n++; seen = 1; end
      else if (seen) tail++;
      start = (mid_at > 0) && busy && (busy_n == mid_at);
      if (start) lr = mid_lr;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic check_pass(input string tag, input int busy_n, input int done_n, input int both_n);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(NBUSY));
    chk({tag, "_done_pulses"}, 64'(done_n), 64'd1);
    chk({tag, "_busy_with_done"}, 64'(both_n), 64'd0);
    chk({tag, "_writes_left"}, 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  initial begin
    int bn, dn, bo;
    vec_t v;
    logic [31:0] rlr;

    vecs[0] = '{"nominal",  32'h0100_0000, 32'h0080_0000, 32'h0080_0000, 32'h0100_0000, 32'h0100_0000, 32'h0080_0000, 32'h0000_0000};
    vecs[1] = '{"neg_grad", 32'hFF00_0000, 32'h0080_0000, 32'h0080_0000, 32'h0100_0000, 32'h0100_0000, 32'h0180_0000, 32'h0200_0000};
    vecs[2] = '{"sat_pos",  32'hFF00_0000, 32'h0100_0000, 32'h0100_0000, 32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    vecs[3] = '{"sat_neg",  32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h8000_0010, 32'h8000_0010, 32'h8000_0000, 32'h8000_0000};
    vecs[4] = '{"floor",    32'hFFFF_FFFF, 32'h0080_0000, 32'h0100_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0002, 32'h0000_0002};
    vecs[5] = '{"lr_zero",  32'h0100_0000, 32'h0080_0000, 32'h0000_0000, 32'h1234_5678, 32'hFEDC_BA98, 32'h1234_5678, 32'hFEDC_BA98};

    rst = 1'b0; start = 1'b0; lr = '0;
    fill_uniform(vecs[0]);
    repeat (3) @(negedge clk);
    chk("reset_ctrl_addr",
        64'({busy, done, w_wr, b_wr, d_rd_addr, x_rd_addr, w_rd_addr, w_wr_addr, b_rd_addr, b_wr_addr}), 64'd0);
    chk("reset_wr_data", {w_wr_data, b_wr_data}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      fill_uniform(v);
      push_table(v);
      run_pass(v.lr, 0, '0, bn, dn, bo);
      check_pass(v.name, bn, dn, bo);
    end

    // start with a different lr mid-pass must be ignored
    v = vecs[0];
    fill_uniform(v);
    push_table(v);
    run_pass(v.lr, 5, 32'h0100_0000, bn, dn, bo);
    check_pass("start_busy", bn, dn, bo);

    for (int k = 0; k < 2; k++) begin
      fill_random();
      rlr = $urandom_range(32'h0400_0000) - 32'h0200_0000;
      push_model(rlr);
      run_pass(rlr, 0, '0, bn, dn, bo);
      check_pass("random", bn, dn, bo);
    end

    // reset during the first MAC cycle of element 4
    v = vecs[0];
    fill_uniform(v);
    push_table(v);
    @(negedge clk);
    start = 1'b1; lr = v.lr;
    @(negedge clk);
    start = 1'b0;
    bn = 0;
    for (int cyc = 0; cyc < 100 && bn < 13; cyc++) begin
      if (busy) bn++;
      if (bn < 13) @(negedge clk);
    end
    chk("abort_reached", 64'(bn), 64'd13);
    rst = 1'b0;
    #1;
    chk("abort_outputs", 64'({busy, done, w_wr, b_wr}), 64'd0);
    chk("abort_writes_done", 64'(NEL - sbq.size()), 64'd4);
    sbq.delete();
    dn = 0;
    repeat (2) begin @(negedge clk); dn += int'(done); end
    rst = 1'b1;
    repeat (6) begin @(negedge clk); dn += int'(done); end
    chk("abort_no_done", 64'(dn), 64'd0);
    fill_uniform(v);
    push_table(v);
    run_pass(v.lr, 0, '0, bn, dn, bo);
    check_pass("after_abort", bn, dn, bo);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/weight_update.md
Name: weight_update

Overview:
- Stage directly downstream of bp: consumes the per-timestep delta gates that bp writes into its dA/dI/dF/dO memories, together with the stored layer inputs.
- Per gate, computes dW[r][c] = sum over t of dgate[t][r]·x[t][c], and dB[r] = sum over t of dgate[t][r].
- Applies the SGD step W ← W − lr·dW (and the same for B), writing back into the weight/bias memories.
- One instance per gate memory; a top-level sequencer starts the four instances.

Parameters:
- WIDTH, 32, data word width.
- FRAC, 24, fractional bits (Q8.24).
- N_ROW, 8, cells (rows of W, entries of B).
- N_COL, 53, inputs (columns of W).
- TIMESTEP, 7, timesteps summed per gradient.
- D_ADDR, 6, dgate memory address width.
- X_ADDR, 9, input memory address width.
- W_ADDR, 9, weight memory address width.
- B_ADDR, 4, bias memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request to begin an update pass.
- lr  in  WIDTH  learning rate in Q(FRAC), sampled when start is accepted.
- busy  out  1  high while a pass is running.
- done  out  1  one-cycle pulse after the final write.
- d_rd_addr  out  D_ADDR  dgate read address.
- d_rd_data  in  WIDTH  dgate data, valid 1 cycle after its address.
- x_rd_addr  out  X_ADDR  input read address.
- x_rd_data  in  WIDTH  input data, 1-cycle latency.
- w_rd_addr  out  W_ADDR  weight read address.
- w_rd_data  in  WIDTH  weight data, 1-cycle latency.
- w_wr  out  1  weight write enable.
- w_wr_addr  out  W_ADDR  weight write address.
- w_wr_data  out  WIDTH  updated weight.
- b_rd_addr  out  B_ADDR  bias read address.
- b_rd_data  in  WIDTH  bias data, 1-cycle latency.
- b_wr  out  1  bias write enable.
- b_wr_addr  out  B_ADDR  bias write address.
- b_wr_data  out  WIDTH  updated bias.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; all counters=0; busy=0; done=0; w_wr=0; b_wr=0; every address and data output=0.
- Element order: r = 0..N_ROW−1 outer, c = 0..N_COL inner. Column c = N_COL is the bias element, with x forced to 1.0 (1<<FRAC).
- Address maps:
  - d_rd_addr = t·N_ROW + r
  - x_rd_addr = t·N_COL + c
  - w_rd/wr_addr = r·N_COL + c
  - b_rd/wr_addr = r
- IDLE:
  - start=1 latches lr and clears the r/c/t counters and the accumulator.
  - Next state MAC; busy=1 from the following cycle.
- MAC (TIMESTEP cycles per element):
  - Cycle t issues the dgate and x addresses for timestep t.
  - At t=0, also issues the w address (or b address for the bias element); the returned value is held in w_old.
  - The data returned for t is accumulated in cycle t+1.
  - After t=TIMESTEP−1, next state WB.
- WB (1 cycle):
  - Adds the last product.
  - upd = sat((lr·acc) >>> FRAC).
  - new = sat(w_old − upd).
  - Asserts w_wr (or b_wr for the bias element) with new for exactly one cycle.
  - Then advances c/r: next element goes to MAC; after the last element (r=N_ROW−1, c=N_COL) the next state is DONE.
- DONE (1 cycle): done=1, busy=0, next state IDLE.
- Total: busy is high for N_ROW·(N_COL+1)·(TIMESTEP+1) cycles, followed by the done pulse.
- Arithmetic:
  - Products are full 2·WIDTH signed, arithmetic-shifted right by FRAC (truncation toward −inf).
  - Accumulator is WIDTH+8 bits signed with no intermediate saturation.
  - sat() clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- start while busy or in DONE: ignored; lr is not re-sampled.
- rst asserted mid-pass: immediate abort to IDLE. A write in progress is dropped and no done pulse is produced. Partial memory contents are left as written.
- w_wr and b_wr are never high in the same cycle.
- No writes occur outside WB.

Decomposition:
- Shared header bp_defs.vh holds:
  - state encodings (IDLE, MAC, WB, DONE);
  - the ONE constant (1<<FRAC);
  - the saturation bounds macro.
  bp and the sequencer include the same header.
- One sub-module, wu_mac: signed multiply, shift by FRAC, guarded accumulate, clear/acc controls, and a saturated output. It is reused for both the gradient sum and the lr scaling.

Test Plan:
- Nominal update. Setup: N_ROW=2, N_COL=2, TIMESTEP=2; all dgate=0x01000000; all x=0x00800000; lr=0x00800000; all W=B=0x01000000. Response: every W write=0x00800000; every B write=0x00000000; busy high for 18 cycles; done pulse on cycle 19.
- Negative gradient. Setup: dgate=0xFF000000 (−1.0), otherwise as above. Response: W=0x01800000, B=0x02000000.
- Saturation. Setup: W=0x7FFFFFF0, dgate=−1.0, x=1.0, lr=1.0. Response: written W=0x7FFFFFFF (clamped, not wrapped).
- Start while busy. Setup: pulse start with lr=0x01000000 mid-pass. Response: ignored; results match the original lr; exactly one done pulse.
- Reset mid-pass. Setup: drop rst during the 5th element's MAC. Response: busy=0, w_wr=0 immediately; no done pulse; a new start afterwards completes a full pass in the nominal cycle count.
- Write ordering. Check: writes are monotone in (r,c); the bias write follows column N_COL−1 of each row; no simultaneous w_wr and b_wr.
